// File: rtl/clock_gen_pkg.sv
// Shared types and sizing for the programmable clock generator.
// Half period is 2^sel reference cycles; the counter is sized for the largest select.
package pa_clock_gen;

  localparam int SEL_W = 3;
  localparam int CNT_W = 2**SEL_W - 1;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_HIGH   = 2'd1,
    ST_PARKED = 2'd2
  } phase_e;

  function automatic logic [CNT_W:0] half_period(input logic [SEL_W-1:0] sel);
    return (CNT_W+1)'(1) << sel;
  endfunction

endpackage

// File: rtl/clock_gen_if.sv
// Control/status bundle between the clock generator and its controller.
interface clock_gen_if;
  import pa_clock_gen::*;

  logic [SEL_W-1:0] clk_sel;
  logic             stop_clk;
  logic             clk_out;
  logic             clk_en;
  logic             running;

  modport master (output clk_sel, stop_clk, input clk_out, clk_en, running);
  modport slave  (input clk_sel, stop_clk, output clk_out, clk_en, running);

endinterface

// File: rtl/clock_gen_sync_2ff.sv
// Multi-flop synchroniser with synchronous active-low clear.
module sync_2ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/clock_gen.sv
// Power-of-two clock divider with glitch-free ratio change and clean stop/start.
//   state     | meaning
//   ST_LOW    | clk_out low, counting a half period
//   ST_HIGH   | clk_out high, counting a half period (always completes)
//   ST_PARKED | clk_out held low, waiting for stop_clk to drop
module clock_gen
  import pa_clock_gen::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_arst,
  clock_gen_if.slave  bus
);

  logic [SEL_W-1:0] w_sel_sync;
  logic             w_stop_sync;
  logic [SEL_W-1:0] r_sel_prev;
  logic [SEL_W-1:0] r_sel_pend;
  logic [SEL_W-1:0] r_sel_q;
  logic [SEL_W-1:0] w_sel_q_nxt;

  phase_e           r_state;
  phase_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_clk_out, w_clk_out_nxt;
  logic             r_clk_en, w_clk_en_nxt;
  logic             r_running, w_running_nxt;
  logic [CNT_W:0]   w_half_tc;
  logic             w_tc;

  sync_2ff #(.WIDTH(SEL_W), .STAGES(SYNC_STAGES)) u_sync_sel (
    .i_clk   (i_clk),
    .i_rst_n (i_arst),
    .i_d     (bus.clk_sel),
    .o_q     (w_sel_sync)
  );

  sync_2ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_stop (
    .i_clk   (i_clk),
    .i_rst_n (i_arst),
    .i_d     (bus.stop_clk),
    .o_q     (w_stop_sync)
  );

  // A select code is only trusted after two equal synchronised samples.
  always_ff @(posedge i_clk) begin
    if (!i_arst) begin
      r_sel_prev <= '0;
      r_sel_pend <= '0;
    end else begin
      r_sel_prev <= w_sel_sync;
      if (w_sel_sync == r_sel_prev) r_sel_pend <= w_sel_sync;
    end
  end

  assign w_half_tc = half_period(r_sel_q) - (CNT_W+1)'(1);
  assign w_tc      = ({1'b0, r_cnt} == w_half_tc);

  always_ff @(posedge i_clk) begin
    if (!i_arst) begin
      r_state   <= ST_LOW;
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_clk_en  <= 1'b0;
      r_running <= 1'b0;
      r_sel_q   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clk_out <= w_clk_out_nxt;
      r_clk_en  <= w_clk_en_nxt;
      r_running <= w_running_nxt;
      r_sel_q   <= w_sel_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_clk_out_nxt = r_clk_out;
    w_clk_en_nxt  = 1'b0;
    w_running_nxt = 1'b1;
    w_sel_q_nxt   = r_sel_q;
    case (r_state)
      ST_LOW: begin
        if (w_tc) begin
          w_cnt_nxt = '0;
          if (w_stop_sync) begin
            w_state_nxt   = ST_PARKED;
            w_running_nxt = 1'b0;
          end else begin
            w_state_nxt   = ST_HIGH;
            w_clk_out_nxt = 1'b1;
            w_clk_en_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (w_tc) begin
          // Falling edge ends a full period: the only safe point to change ratio.
          w_cnt_nxt     = '0;
          w_clk_out_nxt = 1'b0;
          w_sel_q_nxt   = r_sel_pend;
          if (w_stop_sync) begin
            w_state_nxt   = ST_PARKED;
            w_running_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_LOW;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_PARKED: begin
        w_cnt_nxt     = '0;
        w_clk_out_nxt = 1'b0;
        w_running_nxt = 1'b0;
        if (!w_stop_sync) begin
          w_state_nxt   = ST_LOW;
          w_running_nxt = 1'b1;
          w_sel_q_nxt   = r_sel_pend;
        end
      end
      default: begin
        w_state_nxt   = ST_LOW;
        w_cnt_nxt     = '0;
        w_clk_out_nxt = 1'b0;
      end
    endcase
  end

  assign bus.clk_out = r_clk_out;
  assign bus.clk_en  = r_clk_en;
  assign bus.running = r_running;

endmodule

// File: tb/tb_clock_gen.sv
// Scoreboard bench for clock_gen: expected low/high phase lengths are queued by
// the stimulus and popped by a negedge monitor at every clk_out edge.
module tb_clock_gen;
  import pa_clock_gen::*;

  logic clk = 1'b0;
  logic arst;
  int   cyc = -1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_lo[$];
  int   exp_hi[$];

  clock_gen_if bus();

  clock_gen #(.SYNC_STAGES(2)) dut (
    .i_clk  (clk),
    .i_arst (arst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_n(input int lo, input int hi, input int n);
    repeat (n) begin
      exp_lo.push_back(lo);
      exp_hi.push_back(hi);
    end
  endtask

  task automatic go(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: measures phase lengths in clk cycles and checks clk_en alignment.
  logic m_prev;
  logic m_rise, m_fall;
  bit   m_seen_run;
  int   m_lo, m_hi;

  always @(negedge clk) begin
    if (arst !== 1'b1) begin
      m_prev     = 1'b0;
      m_lo       = 0;
      m_hi       = 0;
      m_seen_run = 1'b0;
    end else begin
      m_rise = bus.clk_out && !m_prev;
      m_fall = !bus.clk_out && m_prev;
      if (bus.running) m_seen_run = 1'b1;
      if (m_rise) begin
        check("en_at_rise", int'(bus.clk_en), 1);
        if (exp_lo.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL low_phase at cycle %0d: got rise after %0d low cycles, expected no rise", cyc, m_lo);
        end else begin
          check("low_phase", m_lo, exp_lo.pop_front());
        end
        m_hi = 0;
      end else if (bus.clk_en) begin
        n_tests++;
        n_fail++;
        $display("FAIL en_spurious at cycle %0d: got clk_en=1, expected 0", cyc);
      end
      if (m_fall) begin
        if (exp_hi.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL high_phase at cycle %0d: got fall after %0d high cycles, expected no fall", cyc, m_hi);
        end else begin
          check("high_phase", m_hi, exp_hi.pop_front());
        end
        m_lo = 0;
      end
      if (bus.clk_out) m_hi++;
      else if (bus.running || !m_seen_run) m_lo++;
      else m_lo = 0;
      m_prev = bus.clk_out;
    end
  end

  initial begin
    arst         = 1'b0;
    bus.clk_sel  = '0;
    bus.stop_clk = 1'b0;

    go(2);
    check("rst_clk_out", int'(bus.clk_out), 0);
    check("rst_clk_en",  int'(bus.clk_en),  0);
    check("rst_running", int'(bus.running), 0);

    // /2 from reset: first rise one cycle after release, six periods before /16 lands
    push_n(1, 1, 6);
    arst = 1'b1;

    go(9);
    push_n(8, 8, 2);
    bus.clk_sel = 3'd3;

    go(32);
    push_n(128, 128, 1);
    bus.clk_sel = 3'd7;

    // back to /2 during the 128-cycle high phase: must wait for the fall
    go(200);
    push_n(1, 1, 22);
    bus.clk_sel = 3'd0;
    go(250);
    check("run_sel7", int'(bus.running), 1);

    go(310);
    for (int i = 0; i < 20; i++) begin
      bus.clk_sel = (i % 2 == 0) ? 3'd5 : 3'd6;
      go(cyc + 1);
    end
    bus.clk_sel = 3'd0;

    go(340);
    push_n(4, 4, 3);
    bus.clk_sel = 3'd2;

    go(366);
    bus.stop_clk = 1'b1;
    go(380);
    check("park_clk_out", int'(bus.clk_out), 0);
    check("park_running", int'(bus.running), 0);

    go(390);
    push_n(4, 4, 3);
    bus.stop_clk = 1'b0;
    go(399);
    check("restart_running", int'(bus.running), 1);

    // ratio change and stop meeting at the same fall; restart at /4
    go(412);
    push_n(2, 2, 2);
    bus.clk_sel = 3'd1;
    go(413);
    bus.stop_clk = 1'b1;
    go(425);
    check("park2_running", int'(bus.running), 0);
    go(430);
    bus.stop_clk = 1'b0;

    // stop raised in a high phase too late for its fall: parks at end of low
    go(440);
    bus.stop_clk = 1'b1;
    go(446);
    check("park3_clk_out", int'(bus.clk_out), 0);
    check("park3_running", int'(bus.running), 0);
    go(450);
    push_n(2, 2, 1);
    bus.stop_clk = 1'b0;

    go(459);
    check("pre_rst_high", int'(bus.clk_out), 1);
    arst        = 1'b0;
    bus.clk_sel = 3'd0;
    go(460);
    check("midrst_clk_out", int'(bus.clk_out), 0);
    check("midrst_clk_en",  int'(bus.clk_en),  0);
    check("midrst_running", int'(bus.running), 0);

    go(461);
    push_n(1, 1, 2);
    arst = 1'b1;

    go(466);
    check("exp_lo_drained", exp_lo.size(), 0);
    check("exp_hi_drained", exp_hi.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
